// File: rtl/register_file_mp_if.sv
// register_file_mp_if
//   Bus bundle between the issue/writeback stages and the multi-port
//   register file.
//   master : issue/writeback side; drives read addresses, both write ports
//            and the scoreboard mark, and receives read data and status.
//   slave  : register file side.
//   Signals:
//     RA         read addresses, port k = RA[k*AW +: AW]
//     RD         read data,      port k = RD[k*FW +: FW]
//     RD_BUSY    per read port: addressed register has a pending write
//     WE0/WA0/WD0  write port 0 (ALU writeback)
//     WE1/WA1/WD1  write port 1 (late/memory writeback, clears busy)
//     MARK/MARK_ADDR  set busy bit at next edge
//     WR_COLLIDE registered: both ports wrote the same address last cycle
//     BUSY_CNT   registered count of busy registers
interface register_file_mp_if #(
  parameter int FILE_WIDTH         = 32,
  parameter int FILE_ADDRESS_WIDTH = 5,
  parameter int NUM_RD             = 3
) ();
  logic [NUM_RD*FILE_ADDRESS_WIDTH-1:0] RA;
  logic [NUM_RD*FILE_WIDTH-1:0]         RD;
  logic [NUM_RD-1:0]                    RD_BUSY;
  logic                                 WE0;
  logic [FILE_ADDRESS_WIDTH-1:0]        WA0;
  logic [FILE_WIDTH-1:0]                WD0;
  logic                                 WE1;
  logic [FILE_ADDRESS_WIDTH-1:0]        WA1;
  logic [FILE_WIDTH-1:0]                WD1;
  logic                                 MARK;
  logic [FILE_ADDRESS_WIDTH-1:0]        MARK_ADDR;
  logic                                 WR_COLLIDE;
  logic [FILE_ADDRESS_WIDTH:0]          BUSY_CNT;

  modport master (
    output RA, WE0, WA0, WD0, WE1, WA1, WD1, MARK, MARK_ADDR,
    input  RD, RD_BUSY, WR_COLLIDE, BUSY_CNT
  );

  modport slave (
    input  RA, WE0, WA0, WD0, WE1, WA1, WD1, MARK, MARK_ADDR,
    output RD, RD_BUSY, WR_COLLIDE, BUSY_CNT
  );
endinterface

// File: rtl/register_file_mp.sv
// register_file_mp
//   Multi-port MIPS register file: NUM_RD combinational read ports, two
//   synchronous write ports (port 0 ALU writeback, port 1 late/memory
//   writeback) and a per-register busy scoreboard for hazard stalls.
//   Ports:
//     CLK  rising-edge clock
//     RST  asynchronous reset, active-low (clears data, busy bits, status)
//     bus  register_file_mp_if.slave (read ports, write ports, mark, status)
//   Optional feature: define RF_BYPASS_EN to forward same-cycle write data
//   and busy clears to the read ports. Without it, reads show stored state.
module register_file_mp #(
  parameter int FILE_WIDTH         = 32,
  parameter int FILE_DEPTH         = 32,
  parameter int FILE_ADDRESS_WIDTH = 5,
  parameter int NUM_RD             = 3,
  parameter int ZERO_REG           = 1
) (
  input logic                 CLK,
  input logic                 RST,
  register_file_mp_if.slave   bus
);
  localparam int FW = FILE_WIDTH;
  localparam int AW = FILE_ADDRESS_WIDTH;
  localparam int CW = FILE_ADDRESS_WIDTH + 1;
  localparam bit ZR = (ZERO_REG != 0);

  logic [FW-1:0]         regs_reg [FILE_DEPTH];
  logic [FILE_DEPTH-1:0] busy_reg;
  logic [FILE_DEPTH-1:0] busy_next;
  logic [CW-1:0]         busy_cnt_reg;
  logic [CW-1:0]         busy_cnt_next;
  logic                  collide_reg;
  logic                  collide_next;
  logic                  we0_ok;
  logic                  we1_ok;
  logic                  mark_ok;

  // Register 0 is hard-wired when ZERO_REG: its writes and marks are
  // filtered here so nothing downstream needs to special-case it.
  always_comb begin
    we0_ok       = bus.WE0  && !(ZR && (bus.WA0 == '0));
    we1_ok       = bus.WE1  && !(ZR && (bus.WA1 == '0));
    mark_ok      = bus.MARK && !(ZR && (bus.MARK_ADDR == '0));
    collide_next = we0_ok && we1_ok && (bus.WA0 == bus.WA1);
  end

  // Scoreboard next state: clear applied first so a same-cycle MARK to the
  // same register wins (it represents a new outstanding operation).
  always_comb begin
    busy_next = busy_reg;
    if (we1_ok)  busy_next[bus.WA1]       = 1'b0;
    if (mark_ok) busy_next[bus.MARK_ADDR] = 1'b1;
    busy_cnt_next = '0;
    for (int i = 0; i < FILE_DEPTH; i++) begin
      busy_cnt_next = busy_cnt_next + CW'(busy_next[i]);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < FILE_DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
      collide_reg  <= 1'b0;
    end else begin
      // Port 1 wins an address collision; port 0 is suppressed outright.
      if (we0_ok && !collide_next) regs_reg[bus.WA0] <= bus.WD0;
      if (we1_ok)                  regs_reg[bus.WA1] <= bus.WD1;
      busy_reg     <= busy_next;
      busy_cnt_reg <= busy_cnt_next;
      collide_reg  <= collide_next;
    end
  end

  assign bus.WR_COLLIDE = collide_reg;
  assign bus.BUSY_CNT   = busy_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0] ra;
      logic [FW-1:0] rd_data;
      logic          rd_busy;

      assign ra = bus.RA[gi*AW +: AW];

      always_comb begin
        rd_data = regs_reg[ra];
        rd_busy = busy_reg[ra];
`ifdef RF_BYPASS_EN
        if (we1_ok && (bus.WA1 == ra)) begin
          rd_data = bus.WD1;
          if (!(mark_ok && (bus.MARK_ADDR == ra))) rd_busy = 1'b0;
        end else if (we0_ok && (bus.WA0 == ra)) begin
          rd_data = bus.WD0;
        end
`endif
        if (ZR && (ra == '0)) begin
          rd_data = '0;
          rd_busy = 1'b0;
        end
      end

      assign bus.RD[gi*FW +: FW] = rd_data;
      assign bus.RD_BUSY[gi]     = rd_busy;
    end
  endgenerate
endmodule
